// File: rtl/fetch_pkg.sv
// Shared widths, halt encoding and state type for the instruction fetch unit.
package fetch_pkg;

  localparam int PC_W      = 10;
  localparam int INSTR_W   = 9;
  localparam int LUT_IDX_W = 5;
  localparam int LUT_DEPTH = 1 << LUT_IDX_W;

  localparam logic [INSTR_W-1:0] HALT_WORD = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC,
    DONE
  } fetch_state_t;

endpackage

// File: rtl/branch_lut.sv
// 32-entry branch target table: one write port, one combinational read port.
// A read in the same cycle as a write to the same entry returns the old value.
module branch_lut
  import fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [LUT_IDX_W-1:0] wr_idx,
  input  logic [PC_W-1:0]      wr_data,
  input  logic [LUT_IDX_W-1:0] rd_idx,
  output logic [PC_W-1:0]      rd_data
);

  logic [PC_W-1:0] entries [LUT_DEPTH];

  // Reset has priority so a write presented during reset is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (wr_en) begin
      entries[wr_idx] <= wr_data;
    end
  end

  assign rd_data = entries[rd_idx];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: drives imem, presents instructions, redirects on decoder branches.
// Optional perf counters (instr_count/branch_count) are enabled by FETCH_PERF_CNT_EN.
module instr_fetch_unit
  import fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 branch_en,
  input  logic [LUT_IDX_W-1:0] branch_idx,
  input  logic                 lut_wr_en,
  input  logic [LUT_IDX_W-1:0] lut_wr_idx,
  input  logic [PC_W-1:0]      lut_wr_addr,
  output logic [PC_W-1:0]      imem_addr,
  input  logic [INSTR_W-1:0]   imem_data,
  output logic [INSTR_W-1:0]   instr,
  output logic                 instr_valid,
  output logic [PC_W-1:0]      pc,
  output logic                 busy,
  output logic                 done
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]          instr_count,
  output logic [15:0]          branch_count
`endif
);

  fetch_state_t    state, state_next;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] lut_target;

  branch_lut u_branch_lut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (lut_wr_en),
    .wr_idx  (lut_wr_idx),
    .wr_data (lut_wr_addr),
    .rd_idx  (branch_idx),
    .rd_data (lut_target)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
      instr <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state == FETCH) begin
        instr <= imem_data;
      end
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = FETCH;
          pc_next    = '0;
        end
      end
      FETCH: begin
        state_next = EXEC;
      end
      EXEC: begin
        if (!stall) begin
          if (instr == HALT_WORD) begin
            state_next = DONE;
          end else begin
            state_next = FETCH;
            pc_next    = branch_en ? lut_target : pc + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The memory has one cycle of read latency, so the address of the next
  // instruction goes out in the cycle before FETCH; during FETCH it equals pc.
  assign imem_addr   = pc_next;
  assign instr_valid = (state == EXEC);
  assign busy        = (state == FETCH) || (state == EXEC);
  assign done        = (state == DONE);

`ifdef FETCH_PERF_CNT_EN
  logic exec_step;
  logic take_branch;
  logic accept_start;

  assign exec_step    = (state == EXEC) && !stall;
  assign take_branch  = exec_step && (instr != HALT_WORD) && branch_en;
  assign accept_start = ((state == IDLE) || (state == DONE)) && start;

  always_ff @(posedge clk) begin
    if (reset || accept_start) begin
      instr_count  <= '0;
      branch_count <= '0;
    end else begin
      if (exec_step && (instr_count != 16'hFFFF)) begin
        instr_count <= instr_count + 16'd1;
      end
      if (take_branch && (branch_count != 16'hFFFF)) begin
        branch_count <= branch_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table, directed corner cases,
// then randomized traffic against a behavioural program-level model.
module tb_instr_fetch_unit;

  localparam logic [8:0] HALT = 9'h1FF;

  logic       clk = 1'b0;
  logic       reset, start, stall, branch_en, lut_wr_en;
  logic [4:0] branch_idx, lut_wr_idx;
  logic [9:0] lut_wr_addr, imem_addr, pc;
  logic [8:0] imem_data, instr;
  logic       instr_valid, busy, done;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] instr_count, branch_count;
`endif

  int cmpCount  = 0;
  int failCount = 0;

  logic [8:0] mem [1024];

  instr_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stall       (stall),
    .branch_en   (branch_en),
    .branch_idx  (branch_idx),
    .lut_wr_en   (lut_wr_en),
    .lut_wr_idx  (lut_wr_idx),
    .lut_wr_addr (lut_wr_addr),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .done        (done)
`ifdef FETCH_PERF_CNT_EN
    ,
    .instr_count  (instr_count),
    .branch_count (branch_count)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory with one cycle of read latency.
  always @(posedge clk) imem_data <= mem[imem_addr];

  typedef struct {
    logic       start;
    logic       stall;
    logic       br_en;
    logic [4:0] br_idx;
    logic       exp_valid;
    logic       exp_busy;
    logic       exp_done;
    logic [9:0] exp_pc;
    logic [8:0] exp_instr;
  } vec_t;

  vec_t vecs [10];

  // Behavioural model: a program is running or not, an instruction is held or not.
  logic       m_run, m_have, m_halt;
  logic [9:0] m_pc;
  logic [8:0] m_instr;
  logic [9:0] m_lut [32];
  int         m_icnt, m_bcnt;

  task checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmpCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task stepCycle;
    @(posedge clk);
    #1;
  endtask

  task idleInputs;
    start = 1'b0; stall = 1'b0; branch_en = 1'b0; branch_idx = '0;
    lut_wr_en = 1'b0; lut_wr_idx = '0; lut_wr_addr = '0;
  endtask

  task doReset;
    idleInputs();
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
  endtask

  task clearMem;
    for (int a = 0; a < 1024; a++) mem[a] = 9'h000;
  endtask

  task writeLut(input logic [4:0] idx, input logic [9:0] addr);
    lut_wr_en = 1'b1; lut_wr_idx = idx; lut_wr_addr = addr;
    stepCycle();
    lut_wr_en = 1'b0;
  endtask

  task startProgram;
    start = 1'b1;
    stepCycle();
    start = 1'b0;
  endtask

  task waitExecAt(input logic [9:0] target, input string name);
    int n;
    n = 0;
    while (!(instr_valid === 1'b1 && pc === target) && n < 64) begin
      stepCycle();
      n++;
    end
    checkOutput(name, {21'b0, instr_valid, pc}, {21'b0, 1'b1, target});
  endtask

  task applyStimulus(input vec_t v);
    start = v.start; stall = v.stall; branch_en = v.br_en; branch_idx = v.br_idx;
  endtask

  task modelReset;
    m_run = 0; m_have = 0; m_halt = 0; m_pc = '0; m_instr = '0;
    m_icnt = 0; m_bcnt = 0;
    for (int i = 0; i < 32; i++) m_lut[i] = '0;
  endtask

  task modelStep;
    logic [9:0] tgt;
    if (reset) begin
      modelReset();
    end else begin
      tgt = m_lut[branch_idx];
      if (!m_run) begin
        if (start) begin
          m_run = 1; m_have = 0; m_halt = 0; m_pc = '0; m_icnt = 0; m_bcnt = 0;
        end
      end else if (!m_have) begin
        m_have  = 1;
        m_instr = mem[m_pc];
      end else if (!stall) begin
        m_have = 0;
        if (m_icnt < 65535) m_icnt++;
        if (m_instr == HALT) begin
          m_run = 0; m_halt = 1;
        end else if (branch_en) begin
          m_pc = tgt;
          if (m_bcnt < 65535) m_bcnt++;
        end else begin
          m_pc = m_pc + 10'd1;
        end
      end
      if (lut_wr_en) m_lut[lut_wr_idx] = lut_wr_addr;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0] expAddr;

    // start, stall, br_en, br_idx | valid, busy, done, pc, instr
    vecs[0] = '{1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 10'd0, 9'h000};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 10'd0, 9'h003};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 10'd1, 9'h003};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 10'd1, 9'h011};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 10'd2, 9'h011};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 10'd2, 9'h1FF};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 10'd2, 9'h1FF};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 10'd0, 9'h1FF};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 10'd0, 9'h003};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 10'd1, 9'h003};

    clearMem();
    mem[0] = 9'h003; mem[1] = 9'h011; mem[2] = HALT;
    doReset();
    $display("[TB] reset state");
    checkOutput("rst_pc", 32'(pc), 32'd0);
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_instr", 32'(instr), 32'd0);
    checkOutput("rst_addr", 32'(imem_addr), 32'd0);

    $display("[TB] sequential flow table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      stepCycle();
      checkOutput($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      checkOutput($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
      checkOutput($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
      checkOutput($sformatf("vec%0d_instr", i), 32'(instr), 32'(vecs[i].exp_instr));
      if (vecs[i].exp_busy && !vecs[i].exp_valid)
        checkOutput($sformatf("vec%0d_addr", i), 32'(imem_addr), 32'(vecs[i].exp_pc));
    end
    idleInputs();

    $display("[TB] branch taken");
    doReset();
    clearMem();
    mem[3] = 9'h0AA; mem[40] = HALT;
    writeLut(5'd5, 10'd40);
    startProgram();
    waitExecAt(10'd3, "br_reach");
    branch_en = 1'b1; branch_idx = 5'd5;
    #1;
    checkOutput("br_addr_comb", 32'(imem_addr), 32'd40);
    stepCycle();
    branch_en = 1'b0;
    checkOutput("br_fetch_addr", 32'(imem_addr), 32'd40);
    checkOutput("br_fetch_pc", 32'(pc), 32'd40);
    stepCycle();
    checkOutput("br_exec_instr", 32'(instr), 32'(HALT));
    stepCycle();
    checkOutput("br_done", 32'(done), 32'd1);
    checkOutput("br_done_pc", 32'(pc), 32'd40);

    $display("[TB] stall with branch pending");
    doReset();
    clearMem();
    mem[7] = 9'h055; mem[200] = HALT;
    writeLut(5'd6, 10'd200);
    startProgram();
    waitExecAt(10'd7, "st_reach");
    stall = 1'b1; branch_en = 1'b1; branch_idx = 5'd6;
    for (int k = 0; k < 3; k++) begin
      stepCycle();
      checkOutput($sformatf("st%0d_pc", k), 32'(pc), 32'd7);
      checkOutput($sformatf("st%0d_instr", k), 32'(instr), 32'h055);
      checkOutput($sformatf("st%0d_valid", k), 32'(instr_valid), 32'd1);
    end
    stall = 1'b0;
    stepCycle();
    branch_en = 1'b0;
    checkOutput("st_redirect_pc", 32'(pc), 32'd200);
    checkOutput("st_redirect_valid", 32'(instr_valid), 32'd0);

    $display("[TB] pc wrap-around");
    doReset();
    clearMem();
    mem[1023] = 9'h005;
    writeLut(5'd1, 10'd1023);
    startProgram();
    waitExecAt(10'd0, "wr_reach0");
    branch_en = 1'b1; branch_idx = 5'd1;
    stepCycle();
    branch_en = 1'b0;
    waitExecAt(10'd1023, "wr_reach1023");
    checkOutput("wr_instr", 32'(instr), 32'h005);
    checkOutput("wr_addr_comb", 32'(imem_addr), 32'd0);
    stepCycle();
    checkOutput("wr_pc", 32'(pc), 32'd0);
    checkOutput("wr_fetch_addr", 32'(imem_addr), 32'd0);

    $display("[TB] LUT write/read collision");
    doReset();
    clearMem();
    mem[100] = 9'h0C3;
    writeLut(5'd2, 10'd20);
    startProgram();
    waitExecAt(10'd0, "co_reach0");
    lut_wr_en = 1'b1; lut_wr_idx = 5'd2; lut_wr_addr = 10'd100;
    branch_en = 1'b1; branch_idx = 5'd2;
    stepCycle();
    lut_wr_en = 1'b0; branch_en = 1'b0;
    checkOutput("co_old_target", 32'(pc), 32'd20);
    waitExecAt(10'd20, "co_reach20");
    branch_en = 1'b1; branch_idx = 5'd2;
    stepCycle();
    branch_en = 1'b0;
    checkOutput("co_new_target", 32'(pc), 32'd100);

    $display("[TB] reset mid-run");
    waitExecAt(10'd100, "rm_reach100");
    reset = 1'b1;
    lut_wr_en = 1'b1; lut_wr_idx = 5'd3; lut_wr_addr = 10'd77;
    stepCycle();
    reset = 1'b0; lut_wr_en = 1'b0;
    checkOutput("rm_pc", 32'(pc), 32'd0);
    checkOutput("rm_instr", 32'(instr), 32'd0);
    checkOutput("rm_valid", 32'(instr_valid), 32'd0);
    checkOutput("rm_busy", 32'(busy), 32'd0);
    checkOutput("rm_addr", 32'(imem_addr), 32'd0);
    startProgram();
    waitExecAt(10'd0, "rm_restart");
    branch_en = 1'b1; branch_idx = 5'd2;
    stepCycle();
    branch_en = 1'b0;
    checkOutput("rm_lut_cleared", 32'(pc), 32'd0);
    waitExecAt(10'd0, "rm_reach0b");
    branch_en = 1'b1; branch_idx = 5'd3;
    stepCycle();
    branch_en = 1'b0;
    checkOutput("rm_write_dropped", 32'(pc), 32'd0);

    $display("[TB] randomized traffic against model");
    for (int a = 0; a < 1024; a++)
      mem[a] = ($urandom_range(0, 15) == 0) ? HALT : 9'($urandom_range(0, 510));
    doReset();
    modelReset();
    for (int i = 0; i < 2000; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      start       = ($urandom_range(0, 9) == 0);
      stall       = ($urandom_range(0, 3) == 0);
      branch_en   = ($urandom_range(0, 2) == 0);
      branch_idx  = 5'($urandom_range(0, 31));
      lut_wr_en   = ($urandom_range(0, 7) == 0);
      lut_wr_idx  = 5'($urandom_range(0, 31));
      lut_wr_addr = 10'($urandom_range(0, 1023));
      #1;
      if (m_run && m_have) begin
        if (stall || m_instr == HALT) expAddr = m_pc;
        else if (branch_en)           expAddr = m_lut[branch_idx];
        else                          expAddr = m_pc + 10'd1;
        checkOutput($sformatf("rnd%0d_next_addr", i), 32'(imem_addr), 32'(expAddr));
      end
      @(posedge clk);
      modelStep();
      #1;
      checkOutput($sformatf("rnd%0d_pc", i), 32'(pc), 32'(m_pc));
      checkOutput($sformatf("rnd%0d_valid", i), 32'(instr_valid), 32'(m_run && m_have));
      checkOutput($sformatf("rnd%0d_busy", i), 32'(busy), 32'(m_run));
      checkOutput($sformatf("rnd%0d_done", i), 32'(done), 32'(m_halt));
      checkOutput($sformatf("rnd%0d_instr", i), 32'(instr), 32'(m_instr));
      if (m_run && !m_have)
        checkOutput($sformatf("rnd%0d_fetch_addr", i), 32'(imem_addr), 32'(m_pc));
`ifdef FETCH_PERF_CNT_EN
      checkOutput($sformatf("rnd%0d_icnt", i), 32'(instr_count), 32'(m_icnt));
      checkOutput($sformatf("rnd%0d_bcnt", i), 32'(branch_count), 32'(m_bcnt));
`endif
    end
    idleInputs();
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

endmodule
